// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer: buffers 32-bit samples in a FIFO and hands fixed-size
// payloads to a request-driven UDP transmitter with an inter-packet gap.
// Optional build macro UDP_TX_SEQ_EN prepends a 32-bit sequence number word
// to every packet.
module udp_tx_packetizer #(
  parameter int unsigned PKT_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned IPG_CYCLES = 32,
  parameter logic [31:0] SRC_IP     = 32'hC0A8_0002,
  parameter logic [31:0] DST_IP     = 32'hC0A8_0003,
  parameter logic [15:0] SRC_PORT   = 16'd8080,
  parameter logic [15:0] DST_PORT   = 16'd8080
) (
  input  logic        e_rxc,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic        sample_ready,
  output logic        tx_start,
  input  logic        tx_data_req,
  output logic [31:0] tx_data,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic [31:0] src_ip_addr,
  output logic [31:0] dst_ip_addr,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic        overflow,
  output logic [15:0] pkt_count
);

`ifdef UDP_TX_SEQ_EN
  localparam int unsigned N_WORDS = PKT_WORDS + 1;
`else
  localparam int unsigned N_WORDS = PKT_WORDS;
`endif
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WCW = $clog2(N_WORDS + 1);
  localparam int unsigned GW  = $clog2(IPG_CYCLES + 2);

  localparam logic [15:0] DATA_LEN  = 16'(4 * N_WORDS + 8);
  localparam logic [15:0] TOTAL_LEN = 16'(4 * N_WORDS + 28);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [31:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ready_q, ready_d;
  logic           ovf_q, ovf_d;
  logic [1:0]     state_q, state_d;
  logic           start_q, start_d;
  logic [31:0]    data_q, data_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;

  logic        push;
  logic        fire;
  logic        pop;
  logic        last;
  logic [31:0] fire_word;

  assign push = sample_valid & ready_q;
  assign fire = (state_q == S_SEND) & tx_data_req & (word_cnt_q < WCW'(N_WORDS));
  assign last = fire & (word_cnt_q == WCW'(N_WORDS - 1));

`ifdef UDP_TX_SEQ_EN
  logic [31:0] seq_q, seq_d;
  logic        seq_slot;

  // First word of each packet is the sequence number and leaves the FIFO untouched
  assign seq_slot  = (word_cnt_q == '0);
  assign pop       = fire & ~seq_slot;
  assign fire_word = seq_slot ? seq_q : mem_q[rd_ptr_q];

  // Sequence number advances once per completed packet
  always_comb begin
    seq_d = seq_q;
    if (last) seq_d = seq_q + 32'd1;
  end

  // Sequence register
  always_ff @(posedge e_rxc or negedge rst_n) begin
    if (!rst_n) seq_q <= '0;
    else        seq_q <= seq_d;
  end
`else
  assign pop       = fire;
  assign fire_word = mem_q[rd_ptr_q];
`endif

  // FIFO bookkeeping, packet FSM and registered outputs
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q | (sample_valid & ~ready_q);
    state_d    = state_q;
    data_d     = data_q;
    pkt_cnt_d  = pkt_cnt_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (32'(cnt_d) < FIFO_DEPTH);

    // Requests that move no word drive zero; otherwise the last word holds
    if (fire)             data_d = fire_word;
    else if (tx_data_req) data_d = '0;

    case (state_q)
      S_IDLE: begin
        if (32'(cnt_q) >= PKT_WORDS) state_d = S_START;
      end
      S_START: begin
        state_d    = S_SEND;
        word_cnt_d = '0;
      end
      S_SEND: begin
        if (fire) word_cnt_d = word_cnt_q + WCW'(1);
        if (last) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        // A zero gap still spends the single GAP cycle
        if (32'(gap_cnt_q) + 32'd1 >= IPG_CYCLES) state_d = S_IDLE;
        else                                      gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_START);
  end

  // Control and output registers
  always_ff @(posedge e_rxc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      data_q     <= '0;
      pkt_cnt_q  <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      start_q    <= start_d;
      data_q     <= data_d;
      pkt_cnt_q  <= pkt_cnt_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge e_rxc) begin
    if (push) mem_q[wr_ptr_q] <= sample_data;
  end

  assign sample_ready    = ready_q;
  assign tx_start        = start_q;
  assign tx_data         = data_q;
  assign overflow        = ovf_q;
  assign pkt_count       = pkt_cnt_q;
  assign tx_data_length  = DATA_LEN;
  assign tx_total_length = TOTAL_LEN;
  assign src_ip_addr     = SRC_IP;
  assign dst_ip_addr     = DST_IP;
  assign src_port        = SRC_PORT;
  assign dst_port        = DST_PORT;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Scoreboard bench for udp_tx_packetizer (PKT_WORDS=4, FIFO_DEPTH=8, IPG=5).
module tb_udp_tx_packetizer;

  localparam int unsigned PKT   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IPG   = 5;
`ifdef UDP_TX_SEQ_EN
  localparam bit          SEQ      = 1'b1;
  localparam int          N        = 5;
  localparam logic [15:0] EXP_DLEN = 16'd28;
  localparam logic [15:0] EXP_TLEN = 16'd48;
`else
  localparam bit          SEQ      = 1'b0;
  localparam int          N        = 4;
  localparam logic [15:0] EXP_DLEN = 16'd24;
  localparam logic [15:0] EXP_TLEN = 16'd44;
`endif

  logic        clk;
  logic        rst_n;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        sample_ready;
  logic        tx_start;
  logic        tx_data_req;
  logic [31:0] tx_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic [31:0] src_ip_addr;
  logic [31:0] dst_ip_addr;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic        overflow;
  logic [15:0] pkt_count;

  udp_tx_packetizer #(
    .PKT_WORDS (PKT),
    .FIFO_DEPTH(DEPTH),
    .IPG_CYCLES(IPG)
  ) dut (
    .e_rxc          (clk),
    .rst_n          (rst_n),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .sample_ready   (sample_ready),
    .tx_start       (tx_start),
    .tx_data_req    (tx_data_req),
    .tx_data        (tx_data),
    .tx_data_length (tx_data_length),
    .tx_total_length(tx_total_length),
    .src_ip_addr    (src_ip_addr),
    .dst_ip_addr    (dst_ip_addr),
    .src_port       (src_port),
    .dst_port       (dst_port),
    .overflow       (overflow),
    .pkt_count      (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected payload stream, in output order
  logic [31:0] exp_q[$];
  int          bench_idx = 0;
  logic [31:0] seq_exp   = '0;

  task automatic exp_push(input logic [31:0] d);
    if (SEQ && (bench_idx % PKT == 0)) begin
      exp_q.push_back(seq_exp);
      seq_exp = seq_exp + 32'd1;
    end
    exp_q.push_back(d);
    bench_idx++;
  endtask

  // Monitor: follows tx_start / tx_data_req and compares each delivered word
  bit sending = 1'b0;
  bit pend    = 1'b0;
  int left          = 0;
  int start_count   = 0;
  int last_fire_cyc = 0;
  int start_gap     = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sending = 1'b0;
      pend    = 1'b0;
      left    = 0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_data: got %0h, expected no word", tx_data);
        end else begin
          check("tx_data", tx_data, exp_q.pop_front());
        end
      end
      if (sending && tx_data_req && left > 0) begin
        pend = 1'b1;
        left--;
        if (left == 0) begin
          sending       = 1'b0;
          last_fire_cyc = cyc + 1;
        end
      end
      if (tx_start) begin
        sending   = 1'b1;
        left      = N;
        start_count++;
        start_gap = cyc - last_fire_cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int k = 0;
    while (pkt_count != 16'(target) && k < budget) begin
      tick(1);
      k++;
    end
    check("pkt_count", 32'(pkt_count), 32'(target));
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (start_count != target && k < budget) begin
      tick(1);
      k++;
    end
    check("start_count", 32'(start_count), 32'(target));
  endtask

  task automatic check_reset_vals();
    check("rst_sample_ready", 32'(sample_ready), 32'd1);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_fill", 32'(dut.cnt_q), 32'd0);
    check("data_length", 32'(tx_data_length), 32'(EXP_DLEN));
    check("total_length", 32'(tx_total_length), 32'(EXP_TLEN));
    check("src_ip", src_ip_addr, 32'hC0A8_0002);
    check("dst_ip", dst_ip_addr, 32'hC0A8_0003);
    check("src_port", 32'(src_port), 32'd8080);
    check("dst_port", 32'(dst_port), 32'd8080);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    tx_data_req  = 1'b0;
    tick(2);
    check_reset_vals();
    rst_n = 1'b1;
    tick(2);

    // Partial fill must not start a packet; the completing word must
    for (int i = 1; i <= 3; i++) begin
      exp_push(32'(i));
      push(32'(i));
    end
    tick(4);
    check("no_start_partial", 32'(start_count), 32'd0);
    exp_push(32'd4);
    push(32'd4);
    tick(2);
    check("start_after_fill", 32'(start_count), 32'd1);
    tx_data_req = 1'b1;
    wait_pkts(1, 20);
    tick(3);
    check("tx_data_zero_after_pkt", tx_data, 32'd0);
    tx_data_req = 1'b0;
    tick(10);
    check("sb_drained_1", 32'(exp_q.size()), 32'd0);

    // Nine pushes into an 8-deep FIFO with the transmitter stalled
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_push(32'h100 + 32'(i));
      push(32'h100 + 32'(i));
    end
    check("ready_low_when_full", 32'(sample_ready), 32'd0);
    check("overflow_set", 32'(overflow), 32'd1);
    tx_data_req = 1'b1;
    wait_pkts(3, 100);
    check("ipg_min", (start_gap >= int'(IPG)) ? 32'd1 : 32'd0, 32'd1);
    check("ipg_max", (start_gap <= int'(IPG) + 3) ? 32'd1 : 32'd0, 32'd1);
    tick(2);
    tx_data_req = 1'b0;
    tick(10);
    check("sb_drained_2", 32'(exp_q.size()), 32'd0);
    check("fill_empty", 32'(dut.cnt_q), 32'd0);
    check("no_pkt_from_dropped", 32'(start_count), 32'd3);
    check("ready_back_high", 32'(sample_ready), 32'd1);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a packet
    for (int i = 1; i <= 4; i++) begin
      exp_push(32'hA0 + 32'(i));
      push(32'hA0 + 32'(i));
    end
    tx_data_req = 1'b1;
    wait_starts(4, 10);
    tick(2);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    bench_idx   = 0;
    seq_exp     = '0;
    tx_data_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("no_start_after_reset", 32'(start_count), 32'd4);

    // Fresh packet after reset
    for (int i = 1; i <= 4; i++) begin
      exp_push(32'hB0 + 32'(i));
      push(32'hB0 + 32'(i));
    end
    tx_data_req = 1'b1;
    wait_pkts(1, 30);
    tick(2);
    tx_data_req = 1'b0;
    tick(10);
    check("sb_drained_3", 32'(exp_q.size()), 32'd0);
    check("start_count_final", 32'(start_count), 32'd5);
    check("data_length_final", 32'(tx_data_length), 32'(EXP_DLEN));

    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end

endmodule

// File: doc/udp_tx_packetizer.md
UDP_TX_PACKETIZER -- requirements
Module: udp_tx_packetizer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PKT_WORDS, 64, payload words per packet (1..FIFO_DEPTH).
- FIFO_DEPTH, 256, sample FIFO depth (power of two).
- IPG_CYCLES, 32, idle cycles between packets.
- SRC_IP, 32'hC0A8_0002, source IP.
- DST_IP, 32'hC0A8_0003, destination IP.
- SRC_PORT, 16'd8080, source port.
- DST_PORT, 16'd8080, destination port.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- e_rxc, in, 1, single clock; reset is asynchronous and active-low.
- rst_n, in, 1, asynchronous active-low reset.
- sample_valid, in, 1, sample word offered.
- sample_data, in, 32, sample word.
- sample_ready, out, 1, FIFO can accept a word.
- tx_start, out, 1, one-cycle packet start pulse to the UDP transmitter.
- tx_data_req, in, 1, UDP transmitter requests a payload word.
- tx_data, out, 32, payload word.
- tx_data_length, out, 16, UDP length in bytes.
- tx_total_length, out, 16, IP total length in bytes.
- src_ip_addr / dst_ip_addr, out, 32, equal to SRC_IP / DST_IP.
- src_port / dst_port, out, 16, equal to SRC_PORT / DST_PORT.
- overflow, out, 1, sticky; a sample was offered while the FIFO was full.
- pkt_count, out, 16, packets completed, wraps at 65535 to 0.

Function
REQ-003 A sample SHALL be written when sample_valid && sample_ready; sample_ready SHALL equal (fill level < FIFO_DEPTH).
REQ-004 Push and pop in the same cycle SHALL leave the fill level unchanged; at full, ready is low, so no push occurs.
REQ-005 sample_valid while the FIFO is full SHALL set overflow until reset; the word SHALL be dropped.
REQ-006 The FSM SHALL have states IDLE, START, SEND and GAP.
REQ-007 IDLE->START SHALL occur when the fill level >= PKT_WORDS.
REQ-008 In START, tx_start SHALL be high for exactly one cycle, then the FSM SHALL go to SEND.
REQ-009 In SEND, each cycle with tx_data_req high SHALL pop one word; that word SHALL appear on tx_data the following cycle (one-cycle latency) and hold until the next pop.
REQ-010 After PKT_WORDS pops, the FSM SHALL go to GAP and pkt_count SHALL increment.
REQ-011 tx_data_req high outside SEND, or beyond the packet word count, SHALL pop nothing; tx_data SHALL then be 32'h0.
REQ-012 GAP SHALL last IPG_CYCLES cycles, then the FSM SHALL return to IDLE; IPG_CYCLES=0 SHALL go to IDLE the next cycle.
REQ-013 tx_data_length SHALL equal 4*N+8 and tx_total_length SHALL equal 4*N+28, where N is the words per packet, computed in 16 bits, constant between resets.
REQ-014 Sample pushes SHALL continue in every FSM state.

Reset
REQ-015 While rst_n is low, all outputs SHALL be 0 except sample_ready=1 and the address/port/length constants; the FIFO SHALL be empty, the FSM in IDLE, and overflow/pkt_count 0.
REQ-016 Reset asserted mid-packet SHALL abort immediately, discard FIFO contents, and emit no further tx_start until refilled.

Configuration
REQ-017 With UDP_TX_SEQ_EN defined:
- Each packet SHALL carry N=PKT_WORDS+1 words.
- The first word SHALL be a 32-bit sequence number (0 after reset, +1 per packet, wrapping); it is not popped from the FIFO.
- The remaining PKT_WORDS words SHALL come from the FIFO.
REQ-018 Without UDP_TX_SEQ_EN, N SHALL equal PKT_WORDS and no sequence logic SHALL exist.

Verification
REQ-019 Bench SHALL cover:
- PKT_WORDS=4, push 1..4, tx_data_req held high -> one tx_start, tx_data 1,2,3,4 on the cycles after requests, tx_data_length=24, tx_total_length=44, pkt_count=1.
- Push 3 words with PKT_WORDS=4 -> no tx_start; 4th push -> tx_start within 2 cycles.
- FIFO_DEPTH=8, 9 pushes with no requests -> sample_ready low after 8, overflow=1, first 8 words intact.
- IPG_CYCLES=5, 8 words queued -> second tx_start no earlier than 5 cycles after the first packet's last pop.
- rst_n low mid-SEND -> outputs at reset values, fill level 0; new 4 words -> a normal packet.
- UDP_TX_SEQ_EN, two packets -> first words 0 and 1, tx_data_length=28.
